// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the colour sort sequencer
package sort_pkg;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2,
        CH_C = 2'd3
    } chan_t;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_GATE   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // TCS3200 {s2,s3} filter select codes
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    // TCS3200 {s0,s1} output frequency scaling
    localparam logic [1:0] SCALE_OFF   = 2'b00;
    localparam logic [1:0] SCALE_20PCT = 2'b10;

    function automatic logic [1:0] filter_code(input chan_t ch);
        logic [1:0] code;
        case (ch)
            CH_R:    code = FILT_RED;
            CH_G:    code = FILT_GREEN;
            CH_B:    code = FILT_BLUE;
            default: code = FILT_CLEAR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pulse_counter.sv
// rtl/pulse_counter.sv - synchronised rising-edge counter with saturation
module pulse_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_in,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             rise;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            count <= '0;
        end else begin
            sync1 <= sensor_in;
            sync2 <= sync1;
            prev  <= sync2;
            count <= count_next;
        end
    end

    assign rise = sync2 & ~prev;

    // Exposed as the next value so an edge on the final gate cycle still lands in the latch
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && rise && (count != CNT_MAX)) begin
            count_next = count + CNT_ONE;
        end
    end

endmodule

// File: rtl/sort_sequencer.sv
// rtl/sort_sequencer.sv - TCS3200 filter sequencing, colour classification and sort gate control
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int SETTLE_CYCLES = 100_000,
    parameter int GATE_CYCLES   = 1_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int CNT_W         = 16,
    parameter int MIN_CLEAR     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_out,
    input  logic [2:0] SW,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic       red_detected,
    output logic       green_detected,
    output logic       blue_detected,
    output logic       led0,
    output logic       led1,
    output logic       servo_on,
    output logic       busy
);

    localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      GATE_LAST   = 32'(GATE_CYCLES - 1);
    localparam logic [31:0]      HOLD_LAST   = 32'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_MIN   = CNT_W'(MIN_CLEAR);

    state_t           state, state_nxt;
    chan_t            chan, chan_nxt;
    logic [31:0]      timer, timer_nxt;
    logic             run;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b, cnt_c;
    logic [CNT_W-1:0] count_next;
    logic [2:0]       det, det_q;
    logic             match, reject, gate_end;
    logic             led0_q, led1_q;

    pulse_counter #(
        .CNT_W(CNT_W)
    ) u_pulse_counter (
        .clk        (clk),
        .rst_n      (rst),
        .sensor_in  (sensor_out),
        .clear      (state == ST_SETTLE),
        .enable     (state == ST_GATE),
        .count_next (count_next)
    );

    assign gate_end = (state == ST_GATE) && (timer == GATE_LAST);

    // Bit order matches SW: [0] red, [1] green, [2] blue
    always_comb begin
        det = 3'b000;
        if (cnt_c >= CLEAR_MIN) begin
            if (cnt_r > cnt_g && cnt_r > cnt_b) begin
                det = 3'b001;
            end else if (cnt_g > cnt_r && cnt_g > cnt_b) begin
                det = 3'b010;
            end else if (cnt_b > cnt_r && cnt_b > cnt_g) begin
                det = 3'b100;
            end
        end
    end

    assign match  = |(det & SW);
    assign reject = (|det) && !match;

    always_comb begin
        state_nxt = state;
        chan_nxt  = chan;
        timer_nxt = timer + 32'd1;
        case (state)
            ST_SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    state_nxt = ST_GATE;
                    timer_nxt = '0;
                end
            end
            ST_GATE: begin
                if (timer == GATE_LAST) begin
                    timer_nxt = '0;
                    if (chan == CH_C) begin
                        state_nxt = ST_DECIDE;
                    end else begin
                        state_nxt = ST_SETTLE;
                        chan_nxt  = chan_t'(chan + 2'd1);
                    end
                end
            end
            ST_DECIDE: begin
                timer_nxt = '0;
                chan_nxt  = CH_R;
                state_nxt = match ? ST_HOLD : ST_SETTLE;
            end
            ST_HOLD: begin
                if (timer == HOLD_LAST) begin
                    state_nxt = ST_SETTLE;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_SETTLE;
                chan_nxt  = CH_R;
                timer_nxt = '0;
            end
        endcase
    end

    // run delays the schedule by one clock so the first round starts with the sensor powered up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run    <= 1'b0;
            state  <= ST_SETTLE;
            chan   <= CH_R;
            timer  <= '0;
            cnt_r  <= '0;
            cnt_g  <= '0;
            cnt_b  <= '0;
            cnt_c  <= '0;
            det_q  <= 3'b000;
            led0_q <= 1'b0;
            led1_q <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                state <= state_nxt;
                chan  <= chan_nxt;
                timer <= timer_nxt;
            end
            if (gate_end) begin
                case (chan)
                    CH_R:    cnt_r <= count_next;
                    CH_G:    cnt_g <= count_next;
                    CH_B:    cnt_b <= count_next;
                    default: cnt_c <= count_next;
                endcase
            end
            if (state == ST_DECIDE) begin
                det_q  <= det;
                led1_q <= match;
                led0_q <= (SW == 3'b000 && det != 3'b000) ? ~led0_q : reject;
            end
        end
    end

    assign {s0, s1}       = run ? SCALE_20PCT : SCALE_OFF;
    assign {s2, s3}       = filter_code(chan);
    assign red_detected   = det_q[0];
    assign green_detected = det_q[1];
    assign blue_detected  = det_q[2];
    assign led0           = led0_q;
    assign led1           = led1_q;
    assign servo_on       = (state == ST_HOLD);
    assign busy           = run && (state == ST_SETTLE || state == ST_GATE);

endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Sequences the TCS3200 colour sensor through its four photodiode filters, counts output pulses per filter, and classifies the sample as red, green, blue or none. It then drives the sort gate servo request and the match/reject LEDs according to the switch-selected target colour. It sits between the sensor pins, the switches, and `servo_control` (fed by `servo_on`), and replaces ad-hoc filter cycling with one deterministic measurement schedule.

## Interface
Parameters:
- `SETTLE_CYCLES`, 100_000: clocks after a filter change before counting starts (1 ms at 100 MHz).
- `GATE_CYCLES`, 1_000_000: clocks in each counting window.
- `HOLD_CYCLES`, 50_000_000: clocks `servo_on` is held after a match.
- `CNT_W`, 16: pulse counter width.
- `MIN_CLEAR`, 200: minimum clear-channel count treated as "object present".

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-low.
- `sensor_out` in 1: TCS3200 OUT, asynchronous to `clk`.
- `SW` in 3: target select, one-hot: [0] red, [1] green, [2] blue.
- `s0`, `s1` out 1 each: frequency scaling.
- `s2`, `s3` out 1 each: filter select.
- `red_detected`, `green_detected`, `blue_detected` out 1 each: last classification, one-hot or all zero.
- `led0` out 1: reject indicator.
- `led1` out 1: match indicator.
- `servo_on` out 1: gate-open request to `servo_control`.
- `busy` out 1: high while a measurement round is in progress (SETTLE/GATE).

## Operation
- Filter codes `{s2,s3}`: red 00, green 11, blue 01, clear 10. Channel order: R, G, B, C.
- Scaling: `{s0,s1}`=00 (power-down) while `rst` is low, 10 (20 %) otherwise.
- FSM states:
  - SETTLE: counter cleared and channel filter driven; after SETTLE_CYCLES go to GATE.
  - GATE: count rising edges for GATE_CYCLES, then latch the count into the channel register. If channel is C, go to DECIDE; otherwise advance the channel and go to SETTLE.
  - DECIDE: 1 cycle, classification.
  - HOLD: entered only on match; lasts HOLD_CYCLES, then go to SETTLE on channel R.
- Without a match, DECIDE goes directly to SETTLE on channel R.
- Edge detection: 2-FF synchronizer plus a registered previous value. Only rising edges are counted.
- Counter saturates at 2^CNT_W−1 and never wraps.
- Classification:
  - C < MIN_CLEAR gives none.
  - Otherwise the channel among R/G/B strictly greater than both others is the result.
  - Any tie for maximum gives none.
- SW is sampled only in DECIDE.
  - `match` = (detected one-hot & SW) ≠ 0.
  - `reject` = detected ≠ none and not match.
- Output updates, taken on the cycle after DECIDE:
  - detected flags are registered and held until the next DECIDE.
  - `led1` = match.
  - `led0` = reject, except when SW==000 and something is detected: then `led0` toggles on each DECIDE (flicker).
  - `servo_on` is high for the whole of HOLD, low otherwise.
- SW with more than one bit set: a match is allowed on any selected colour.

## Timing
- Reset values:
  - state SETTLE, channel R.
  - `s0=s1=0`, `{s2,s3}=00`.
  - all detected flags 0; `led0=led1=servo_on=0`; `busy=0`.
  - counters and channel registers 0.
- First cycle after reset release: `s0=1`, `busy=1`, SETTLE starts.
- Edge latency: a `sensor_out` rise is counted 3 clocks later if GATE is still active. Edges inside SETTLE are discarded.
- Round length without match: 4·(SETTLE_CYCLES+GATE_CYCLES)+1 clocks. With match, add HOLD_CYCLES.
- `{s2,s3}` changes on the first cycle of each SETTLE.
- `busy` falls in DECIDE and stays low through HOLD.
- Reset asserted mid-round or mid-HOLD: all outputs go immediately (asynchronously) to reset values. The partial measurement is discarded.
- An edge and the GATE end on the same cycle: the edge is counted.

## Structure
- Package `sort_pkg`:
  - channel enum (R, G, B, C) and the filter-code constants.
  - FSM state enum.
  - `SCALE_20PCT` constant.
- Sub-module `pulse_counter`: synchronizer, edge detect, saturating counter with `clear` and `enable` inputs, CNT_W parameter.
- The FSM, channel registers, classifier and LED/servo logic stay in `sort_sequencer`.

## Test plan
Parameters for all scenarios: SETTLE=10, GATE=100, HOLD=50, MIN_CLEAR=5, CNT_W=8.

- Reset release with `sensor_out` idle:
  - `s0` goes to 1 next cycle and `{s2,s3}` steps 00→11→01→10 at 110-clock intervals.
  - DECIDE occurs at cycle 441 with all detected flags 0, `led0=led1=servo_on=0`.
- Per-channel periods R=4, G=10, B=10, C=3 clocks with SW=001:
  - `red_detected=1`, `led1=1`.
  - `servo_on` high for exactly 50 clocks, then a new round starts.
- Same stimulus with SW=010:
  - `red_detected=1`, `led0=1`, `led1=0`, `servo_on` never rises.
- Tie case R=G=25 counts, B=10, C=30:
  - all flags 0, no servo.
- Clear count 4 (< MIN_CLEAR):
  - result none, regardless of the R/G/B counts.
- Saturation: `sensor_out` toggling every clock (50 rising edges per channel) with CNT_W=5:
  - counts saturate at 31, with no wrap.
- Reset asserted during HOLD:
  - `servo_on`, `led1` and all flags drop the same cycle.
  - Restart begins at SETTLE, channel R.
- Multi-select: SW=101 with blue dominant:
  - `led1=1`, `servo_on` pulses.
